// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the execute-side pipeline blocks.
//   XLEN              datapath width
//   OP1_* / OP2_*     operand source selects coming out of decode
//   fun3_e            ALU function encodings carried on fun3
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic OP1_RS1 = 1'b0;
   localparam logic OP1_PC  = 1'b1;
   localparam logic OP2_RS2 = 1'b0;
   localparam logic OP2_IMM = 1'b1;

   typedef enum logic [2:0] {
      FUN3_ADD_SUB = 3'b000,
      FUN3_SLL     = 3'b001,
      FUN3_SLT     = 3'b010,
      FUN3_SLTU    = 3'b011,
      FUN3_XOR     = 3'b100,
      FUN3_SR      = 3'b101,
      FUN3_OR      = 3'b110,
      FUN3_AND     = 3'b111
   } fun3_e;

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Priority forwarding for one source register. The youngest producer wins:
// EX, then MEM, then WB, otherwise the register-file read.
//   i_src_addr           source register index being resolved
//   i_rf_data            register-file read data for that source
//   i_ex_en/addr/data    EX producer (enable already excludes loads)
//   i_mem_we/addr/data   MEM-stage producer
//   i_wb_we/addr/data    WB-stage producer
//   o_fwd_data           resolved source value
// ---------------------------------------------------------------------------
module fwd_mux
   import riscv_pkg::*;
(
   input  logic [4:0]      i_src_addr,
   input  logic [XLEN-1:0] i_rf_data,
   input  logic            i_ex_en,
   input  logic [4:0]      i_ex_addr,
   input  logic [XLEN-1:0] i_ex_data,
   input  logic            i_mem_we,
   input  logic [4:0]      i_mem_addr,
   input  logic [XLEN-1:0] i_mem_data,
   input  logic            i_wb_we,
   input  logic [4:0]      i_wb_addr,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [XLEN-1:0] o_fwd_data
);

   // x0 is hardwired to zero, so a write aimed at it must never be forwarded;
   // the register file already returns 0 for it.
   logic w_src_nz;
   assign w_src_nz = (i_src_addr != 5'd0);

   always_comb begin
      o_fwd_data = i_rf_data;
      if (w_src_nz && i_ex_en && (i_ex_addr == i_src_addr)) begin
         o_fwd_data = i_ex_data;
      end else if (w_src_nz && i_mem_we && (i_mem_addr == i_src_addr)) begin
         o_fwd_data = i_mem_data;
      end else if (w_src_nz && i_wb_we && (i_wb_addr == i_src_addr)) begin
         o_fwd_data = i_wb_data;
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// Execute-stage operand issue register. Resolves rs1/rs2 through the
// forwarding network, selects and registers the ALU operands and writeback
// control, and raises the load-use stall.
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready + in_*        decoded instruction from decode
//   ex_result                       ALU result of the instruction held here
//   mem_*, wb_*                     later-stage writeback producers
//   flush                           synchronous kill of the held instruction
//   out_valid/out_ready             handshake towards the ALU/EX
//   op1, op2, fun3, aux             ALU operands and function
//   out_rs2_data, out_pc, out_rd_addr, out_reg_we, out_is_load
// ---------------------------------------------------------------------------
module ex_operand_stage
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,

   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [4:0]      in_rs1_addr,
   input  logic [4:0]      in_rs2_addr,
   input  logic [4:0]      in_rd_addr,
   input  logic            in_rs1_used,
   input  logic            in_rs2_used,
   input  logic            in_op1_sel,
   input  logic            in_op2_sel,
   input  logic [2:0]      in_fun3,
   input  logic            in_aux,
   input  logic            in_reg_we,
   input  logic            in_is_load,

   input  logic [XLEN-1:0] ex_result,
   input  logic [4:0]      mem_rd_addr,
   input  logic            mem_reg_we,
   input  logic [XLEN-1:0] mem_rd_data,
   input  logic [4:0]      wb_rd_addr,
   input  logic            wb_reg_we,
   input  logic [XLEN-1:0] wb_rd_data,

   input  logic            flush,

   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [2:0]      fun3,
   output logic            aux,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rd_addr,
   output logic            out_reg_we,
   output logic            out_is_load
);

   logic            r_valid;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   logic [2:0]      r_fun3;
   logic            r_aux;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_pc;
   logic [4:0]      r_rd_addr;
   logic            r_reg_we;
   logic            r_is_load;

   logic            w_ex_fwd_en;
   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;
   logic            w_load_use;
   logic            w_capture;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;

   // A load held here has no data yet (ex_result is only its address), so it
   // is excluded from EX forwarding and handled by the load-use stall instead.
   assign w_ex_fwd_en = r_valid & r_reg_we & ~r_is_load;

   fwd_mux u_fwd_rs1 (
      .i_src_addr (in_rs1_addr),
      .i_rf_data  (in_rs1_data),
      .i_ex_en    (w_ex_fwd_en),
      .i_ex_addr  (r_rd_addr),
      .i_ex_data  (ex_result),
      .i_mem_we   (mem_reg_we),
      .i_mem_addr (mem_rd_addr),
      .i_mem_data (mem_rd_data),
      .i_wb_we    (wb_reg_we),
      .i_wb_addr  (wb_rd_addr),
      .i_wb_data  (wb_rd_data),
      .o_fwd_data (w_fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .i_src_addr (in_rs2_addr),
      .i_rf_data  (in_rs2_data),
      .i_ex_en    (w_ex_fwd_en),
      .i_ex_addr  (r_rd_addr),
      .i_ex_data  (ex_result),
      .i_mem_we   (mem_reg_we),
      .i_mem_addr (mem_rd_addr),
      .i_mem_data (mem_rd_data),
      .i_wb_we    (wb_reg_we),
      .i_wb_addr  (wb_rd_addr),
      .i_wb_data  (wb_rd_data),
      .o_fwd_data (w_fwd_rs2)
   );

   // The dependent instruction waits one cycle; by then the load has moved
   // to MEM and its data arrives through the MEM forwarding path.
   assign w_load_use = r_valid & r_is_load & r_reg_we & (r_rd_addr != 5'd0) &
                       ((in_rs1_used & (r_rd_addr == in_rs1_addr)) |
                        (in_rs2_used & (r_rd_addr == in_rs2_addr)));

   assign in_ready  = ~flush & ~w_load_use & (~r_valid | out_ready);
   assign w_capture = in_valid & in_ready;

   assign w_op1 = (in_op1_sel == OP1_PC)  ? in_pc  : w_fwd_rs1;
   assign w_op2 = (in_op2_sel == OP2_IMM) ? in_imm : w_fwd_rs2;

   // in_ready already excludes flush, so the capture term needs no extra guard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Operands are resolved once at capture and then frozen, so later changes
   // on the forwarding buses cannot disturb an instruction under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op1      <= '0;
         r_op2      <= '0;
         r_fun3     <= 3'd0;
         r_aux      <= 1'b0;
         r_rs2_data <= '0;
         r_pc       <= '0;
         r_rd_addr  <= 5'd0;
         r_reg_we   <= 1'b0;
         r_is_load  <= 1'b0;
      end else if (w_capture) begin
         r_op1      <= w_op1;
         r_op2      <= w_op2;
         r_fun3     <= in_fun3;
         r_aux      <= in_aux;
         r_rs2_data <= w_fwd_rs2;
         r_pc       <= in_pc;
         r_rd_addr  <= in_rd_addr;
         r_reg_we   <= in_reg_we;
         r_is_load  <= in_is_load;
      end
   end

   assign out_valid    = r_valid;
   assign op1          = r_op1;
   assign op2          = r_op2;
   assign fun3         = r_fun3;
   assign aux          = r_aux;
   assign out_rs2_data = r_rs2_data;
   assign out_pc       = r_pc;
   assign out_rd_addr  = r_rd_addr;
   assign out_reg_we   = r_reg_we;
   assign out_is_load  = r_is_load;

endmodule
